// File: rtl/ctrl_xmem_stream.sv
// Stream controller: fills x memory, issues convolution windows as data
// arrives, tracks datapath pipeline and output queue occupancy.
module ctrl_xmem_stream #(
    parameter int X_SIZE     = 128,
    parameter int F_SIZE     = 32,
    parameter int PIPE_DEPTH = 2,
    parameter int OUT_DEPTH  = 4,
    localparam int AW        = $clog2(X_SIZE),
    localparam int CW        = $clog2(X_SIZE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    output logic          xmem_wr_en,
    output logic [AW-1:0] xmem_wr_addr,
    input  logic          conv_start,
    output logic          mac_issue,
    output logic [AW-1:0] mac_win,
    output logic          y_push,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          conv_done,
    output logic          busy
);

    localparam int Y_SIZE = X_SIZE - F_SIZE + 1;
    localparam int QW     = $clog2(OUT_DEPTH + PIPE_DEPTH + 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         x_count_q;
    logic [CW-1:0]         x_count_d;
    logic [CW-1:0]         win_cnt_q;
    logic                  start_pend_q;
    logic [PIPE_DEPTH-1:0] pipe_q;
    logic [PIPE_DEPTH-1:0] pipe_d;
    logic [QW-1:0]         inflight_q;
    logic [QW-1:0]         inflight_d;
    logic [QW-1:0]         occ_q;
    logic [QW-1:0]         occ_d;
    logic                  pop;
    logic                  data_ok;
    logic                  room_ok;

    assign s_ready = !reset && (state_q == FILL || state_q == RUN)
                     && (x_count_q < CW'(X_SIZE));
    assign xmem_wr_en   = s_valid && s_ready;
    assign xmem_wr_addr = x_count_q[AW-1:0];
    assign x_count_d    = x_count_q + CW'(xmem_wr_en);

    // A window may issue only once all of its samples are in memory
    assign data_ok = {1'b0, x_count_q} >= ((CW+1)'(F_SIZE) + {1'b0, win_cnt_q});
    assign room_ok = ({1'b0, inflight_q} + {1'b0, occ_q}) < (QW+1)'(OUT_DEPTH);

    assign mac_issue = !reset && (state_q == RUN) && (win_cnt_q < CW'(Y_SIZE))
                       && data_ok && room_ok;
    assign mac_win   = win_cnt_q[AW-1:0];
    assign y_push    = !reset && pipe_q[PIPE_DEPTH-1];
    assign m_valid   = (occ_q != '0);
    assign pop       = m_valid && m_ready;
    assign conv_done = (state_q == DONE);
    assign busy      = !(state_q == FILL && x_count_q == '0);

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = mac_issue;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        inflight_d = inflight_q;
        unique case ({mac_issue, y_push})
            2'b10:   inflight_d = inflight_q + QW'(1);
            2'b01:   inflight_d = inflight_q - QW'(1);
            default: inflight_d = inflight_q;
        endcase
        occ_d = occ_q;
        unique case ({y_push, pop})
            2'b10:   occ_d = occ_q + QW'(1);
            2'b01:   occ_d = occ_q - QW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            x_count_q    <= '0;
            win_cnt_q    <= '0;
            start_pend_q <= 1'b0;
            pipe_q       <= '0;
            inflight_q   <= '0;
            occ_q        <= '0;
        end else begin
            x_count_q  <= x_count_d;
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            if (mac_issue) begin
                win_cnt_q <= win_cnt_q + CW'(1);
            end
            unique case (state_q)
                FILL: begin
                    // Counting this cycle's write lets the first issue follow it directly
                    if ((conv_start || start_pend_q) && x_count_d >= CW'(F_SIZE)) begin
                        state_q      <= RUN;
                        start_pend_q <= 1'b0;
                    end else if (conv_start) begin
                        start_pend_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (win_cnt_q == CW'(Y_SIZE)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (inflight_q == '0 && occ_q == '0) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q      <= FILL;
                    x_count_q    <= '0;
                    win_cnt_q    <= '0;
                    start_pend_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/ctrl_xmem_stream.md
CTRL_XMEM_STREAM -- requirements
Module: ctrl_xmem_stream

Interface
REQ-001 Parameter X_SIZE, default 128: input samples per convolution run.
REQ-002 Parameter F_SIZE, default 32: filter taps; outputs per run Y_SIZE = X_SIZE-F_SIZE+1.
REQ-003 Parameter PIPE_DEPTH, default 2: cycles from mac_issue to y_push.
REQ-004 Parameter OUT_DEPTH, default 4: output queue entries held in the datapath.
REQ-005 Legal parameters: 1 <= F_SIZE <= X_SIZE, PIPE_DEPTH >= 1, OUT_DEPTH >= 1; AW = $clog2(X_SIZE), CW = $clog2(X_SIZE+1).
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 s_valid  input  1  AXI-style input sample valid.
REQ-009 s_ready  output  1  block can accept an input sample.
REQ-010 xmem_wr_en  output  1  write strobe to x memory, = s_valid && s_ready.
REQ-011 xmem_wr_addr  output  AW  write address, equal to the count of samples accepted this run.
REQ-012 conv_start  input  1  level request to begin producing outputs.
REQ-013 mac_issue  output  1  one-cycle pulse: datapath computes window mac_win.
REQ-014 mac_win  output  AW  index of the window issued, 0..Y_SIZE-1.
REQ-015 y_push  output  1  datapath writes one result into its output queue.
REQ-016 m_valid  output  1  output queue non-empty.
REQ-017 m_ready  input  1  downstream accepts output; a pop occurs when m_valid && m_ready.
REQ-018 conv_done  output  1  one-cycle pulse at end of run.
REQ-019 busy  output  1  high in every state except FILL with zero samples accepted.

Function
REQ-020 States: FILL, RUN, DRAIN, DONE; reset state FILL.
REQ-021 s_ready = 1 in FILL and RUN while x_count < X_SIZE; 0 otherwise; x_count increments on each xmem_wr_en.
REQ-022 FILL -> RUN when conv_start == 1 and x_count >= F_SIZE; conv_start seen earlier in FILL is latched (start_pend) and honoured once x_count >= F_SIZE.
REQ-023 In RUN, mac_issue asserts in any cycle where x_count >= F_SIZE + win_cnt and inflight + occupancy < OUT_DEPTH; win_cnt then increments; at most one issue per cycle.
REQ-024 Input fill overlaps output: writes continue in RUN; x_count and win_cnt are independent counters.
REQ-025 y_push = mac_issue delayed exactly PIPE_DEPTH cycles by a shift register; inflight counts issues not yet pushed.
REQ-026 occupancy +1 on y_push, -1 on pop, unchanged when both occur in the same cycle; never exceeds OUT_DEPTH, never underflows.
REQ-027 m_valid = (occupancy != 0), combinational from the registered occupancy.
REQ-028 RUN -> DRAIN in the cycle after win_cnt reaches Y_SIZE.
REQ-029 DRAIN -> DONE when inflight == 0 and occupancy == 0; conv_done asserts for exactly one cycle on entry to DONE.
REQ-030 DONE -> FILL next cycle; x_count, win_cnt, start_pend cleared, so the next sample writes address 0.
REQ-031 conv_start is ignored in RUN, DRAIN, DONE.
REQ-032 s_valid while s_ready = 0 produces no write and no counter change.

Reset
REQ-033 Reset outputs: s_ready 0, xmem_wr_en 0, xmem_wr_addr 0, mac_issue 0, mac_win 0, y_push 0, m_valid 0, conv_done 0, busy 0.
REQ-034 Reset at any point clears all counters, start_pend and the delay line; in-flight results never produce y_push.
REQ-035 s_ready rises the first cycle after reset deasserts.

Verification (X_SIZE=8, F_SIZE=3, PIPE_DEPTH=2, OUT_DEPTH=2 unless stated)
REQ-036 s_valid=1, conv_start=1, m_ready=1 continuous -> 8 writes at addr 0..7; first mac_issue one cycle after the 3rd write; 6 issues, 6 pops, mac_win 0..5; conv_done one pulse after the last pop.
REQ-037 Run with m_ready=0 for 20 cycles -> exactly 2 mac_issue, m_valid held 1, no further issue until the first pop.
REQ-038 s_valid every 3rd cycle -> each mac_issue occurs one cycle after x_count reaches 3+mac_win; no issue precedes its data.
REQ-039 conv_start=0 until all 8 written -> s_ready falls after the 8th write, zero mac_issue; conv_start pulse one cycle -> all 6 outputs follow.
REQ-040 reset for 1 cycle mid-RUN with 1 result in flight -> no y_push after reset, all outputs at reset values, next run restarts at addr 0.
REQ-041 Two back-to-back runs -> second run's first write at addr 0 the cycle after DONE, 6 outputs each, 2 conv_done pulses.
